// File: rtl/bcd2_seg_scan_if.sv
// bcd2_seg_scan_if: BCD input/load handshake and two-digit seven-segment drive bundle
interface bcd2_seg_scan_if;
  logic [4:0] bcd_in;
  logic       load;
  logic       blank;
  logic       load_ack;
  logic       err;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [1:0] an_n;
  modport master(output bcd_in, load, blank, input load_ack, err, seg_n, dp_n, an_n);
  modport slave(input bcd_in, load, blank, output load_ack, err, seg_n, dp_n, an_n);
endinterface

// File: rtl/bcd2_seg_scan.sv
// bcd2_seg_scan: latches a 5-bit BCD value and scans it onto two common-anode digits (clk, rst_n, io: bcd_in/load/blank in, load_ack/err/seg_n/dp_n/an_n out)
module bcd2_seg_scan #(
  parameter int CLK_DIV  = 4,
  parameter int GAP_CYC  = 1,
  parameter int BLANK_LZ = 1
) (
  input  logic clk,
  input  logic rst_n,
  bcd2_seg_scan_if.slave io
);
  localparam int CW = $clog2(CLK_DIV > GAP_CYC ? CLK_DIV : GAP_CYC);
  typedef enum logic [2:0] {OFF, DIG0, GAP0, DIG1, GAP1} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0] hold, shown, shown_nxt;
  logic [1:0] an_nxt;
  logic [6:0] seg_nxt;
  logic done;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0000110;
    endcase
  endfunction
  always_comb begin
    done = cnt == ((state == DIG0 || state == DIG1) ? CW'(CLK_DIV - 1) : CW'(GAP_CYC - 1));
    state_nxt = state;
    if (io.blank) state_nxt = OFF;
    else
      case (state)
        OFF:     state_nxt = DIG0;
        DIG0:    state_nxt = done ? GAP0 : DIG0;
        GAP0:    state_nxt = done ? DIG1 : GAP0;
        DIG1:    state_nxt = done ? GAP1 : DIG1;
        GAP1:    state_nxt = done ? DIG0 : GAP1;
        default: state_nxt = OFF;
      endcase
    // OFF parks the counter at zero so a long blank can never overflow it
    cnt_nxt = (state_nxt != state || state_nxt == OFF) ? '0 : cnt + 1'b1;
    // new value is only taken at a frame start, so a frame never tears
    shown_nxt = (state_nxt == DIG0 && state != DIG0) ? hold : shown;
    // a blanked leading zero still occupies its full slot to keep brightness even
    an_nxt = state_nxt == DIG0 ? 2'b10 :
             state_nxt == DIG1 ? ((BLANK_LZ != 0 && !shown_nxt[4]) ? 2'b11 : 2'b01) : 2'b11;
    seg_nxt = state_nxt == DIG0 ? dec(shown_nxt[3:0]) :
              state_nxt == DIG1 ? dec({3'b000, shown_nxt[4]}) : 7'h7F;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= OFF;
      cnt         <= '0;
      hold        <= '0;
      shown       <= '0;
      io.an_n     <= 2'b11;
      io.seg_n    <= 7'h7F;
      io.load_ack <= 1'b0;
      io.err      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      shown       <= shown_nxt;
      io.an_n     <= an_nxt;
      io.seg_n    <= seg_nxt;
      io.load_ack <= io.load;
      io.err      <= hold[3:0] > 4'd9;
      if (io.load) hold <= io.bcd_in;
    end
  assign io.dp_n = 1'b1;
  a_one_anode: assert property (@(posedge clk) disable iff (!rst_n) io.an_n != 2'b00);
endmodule

// File: tb/tb_bcd2_seg_scan.sv
// tb_bcd2_seg_scan: directed stimulus with a queued scoreboard for both leading-zero settings
module tb_bcd2_seg_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bcd2_seg_scan_if io0();
  bcd2_seg_scan_if io1();
  assign io1.bcd_in = io0.bcd_in;
  assign io1.load   = io0.load;
  assign io1.blank  = io0.blank;
  bcd2_seg_scan #(.CLK_DIV(4), .GAP_CYC(1), .BLANK_LZ(1)) u0 (.clk(clk), .rst_n(rst_n), .io(io0.slave));
  bcd2_seg_scan #(.CLK_DIV(4), .GAP_CYC(1), .BLANK_LZ(0)) u1 (.clk(clk), .rst_n(rst_n), .io(io1.slave));
  typedef struct packed {
    logic [1:0] a0;
    logic [1:0] a1;
    logic [6:0] s;
    logic       sc;
    logic       ack;
    logic       err;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  logic [4:0] m_hold = '0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", n, act, req);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("an0", {30'd0, io0.an_n}, {30'd0, e.a0});
      chk("an1", {30'd0, io1.an_n}, {30'd0, e.a1});
      if (e.sc) chk("seg0", {25'd0, io0.seg_n}, {25'd0, e.s});
      chk("seg1", {25'd0, io1.seg_n}, {25'd0, e.s});
      chk("ack0", {31'd0, io0.load_ack}, {31'd0, e.ack});
      chk("ack1", {31'd0, io1.load_ack}, {31'd0, e.ack});
      chk("err0", {31'd0, io0.err}, {31'd0, e.err});
      chk("err1", {31'd0, io1.err}, {31'd0, e.err});
      chk("dp", {30'd0, io0.dp_n, io1.dp_n}, 32'd3);
      chk("an_both_low", {31'd0, io0.an_n == 2'b00 || io1.an_n == 2'b00}, 32'd0);
    end
  task automatic step(input logic [1:0] a0, input logic [1:0] a1, input logic [6:0] s, input logic sc);
    logic ld;
    logic [4:0] b;
    exp_t x;
    ld = io0.load;
    b = io0.bcd_in;
    @(posedge clk);
    #1;
    x.a0 = a0;
    x.a1 = a1;
    x.s = s;
    x.sc = sc;
    x.ack = ld;
    x.err = m_hold[3:0] > 4'd9;
    if (ld) m_hold = b;
    q.push_back(x);
    io0.load = 1'b0;
  endtask
  task automatic off_step();
    step(2'b11, 2'b11, 7'h7F, 1'b1);
  endtask
  task automatic frame(input logic [6:0] s0, input logic tens, input int ld_i, input logic [4:0] ld_v, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == ld_i) begin
        io0.load = 1'b1;
        io0.bcd_in = ld_v;
      end
      if (i < 4) step(2'b10, 2'b10, s0, 1'b1);
      else if (i == 4 || i == 9) off_step();
      else step(tens ? 2'b01 : 2'b11, 2'b01, tens ? 7'b1111001 : 7'b1000000, tens);
    end
  endtask
  task automatic async_rst();
    exp_t x;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_hold = '0;
    x.a0 = 2'b11;
    x.a1 = 2'b11;
    x.s = 7'h7F;
    x.sc = 1'b1;
    x.ack = 1'b0;
    x.err = 1'b0;
    q.push_back(x);
  endtask
  initial begin
    io0.bcd_in = '0;
    io0.load = 1'b0;
    io0.blank = 1'b0;
    off_step();
    off_step();
    rst_n = 1'b1;
    frame(7'b1000000, 1'b0, 1, 5'b10011, 10);
    frame(7'b0110000, 1'b1, -1, 5'b0, 10);
    frame(7'b0110000, 1'b1, 2, 5'b01100, 10);
    frame(7'b0000110, 1'b0, 0, 5'b00111, 10);
    frame(7'b1111000, 1'b0, -1, 5'b0, 7);
    io0.blank = 1'b1;
    off_step();
    io0.load = 1'b1;
    io0.bcd_in = 5'b10101;
    off_step();
    off_step();
    io0.blank = 1'b0;
    frame(7'b0010010, 1'b1, 0, 5'b10011, 10);
    frame(7'b0110000, 1'b1, -1, 5'b0, 2);
    async_rst();
    off_step();
    rst_n = 1'b1;
    frame(7'b1000000, 1'b0, -1, 5'b0, 10);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain left=%0d req=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd2_seg_scan.md
Name: bcd2_seg_scan

Overview:
Downstream consumer of the 4-bit binary-to-BCD converter. Takes its 5-bit BCD result: bit 4 is the tens digit (0/1), bits 3:0 are the units digit. Latches the value on a load strobe and time-multiplexes two common-anode seven-segment digits. Includes anti-ghosting gap, leading-zero blanking and invalid-code flagging.

Parameters:
CLK_DIV, 4, clk cycles each digit is lit (>=2)
GAP_CYC, 1, clk cycles both anodes are off between digits (>=1)
BLANK_LZ, 1, 1 = suppress the tens digit when it is 0

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
bcd_in  in  5  BCD from converter; [4]=tens, [3:0]=units
load  in  1  sample bcd_in into hold register at this edge
blank  in  1  1 = display off, scan halted
load_ack  out  1  one-cycle pulse, cycle after a load edge
err  out  1  held units code >9
seg_n  out  7  active-low segments, [6:0]=g..a
dp_n  out  1  active-low decimal point, always 1
an_n  out  2  active-low anodes; [0]=units, [1]=tens

Behaviour:
- Reset (async, rst_n=0): state OFF; hold=0; shown=0; counter=0; an_n=2'b11; seg_n=7'h7F; dp_n=1; load_ack=0; err=0.
- All outputs are registered. Output values match the state they are entered with, on the same edge.
- Hold register:
  - load=1 at an edge: hold<=bcd_in and load_ack=1 for the next cycle.
  - Load is independent of state and blank.
  - Back-to-back loads: each load pulses load_ack; the last value wins.
- err = (hold[3:0] > 9). It is registered: valid the cycle after hold updates.
- Shown snapshot:
  - shown<=hold on every transition into DIG0 (including from OFF).
  - The display never tears mid-frame; a new value appears at the next frame start.
- FSM states: OFF, DIG0, GAP0, DIG1, GAP1.
  - OFF: an_n=11. Next state DIG0 when blank=0.
  - DIG0: an_n=10, seg_n=decode(shown[3:0]). Held CLK_DIV cycles, then GAP0.
  - GAP0: an_n=11, seg_n=7'h7F. Held GAP_CYC cycles, then DIG1.
  - DIG1: an_n=01, seg_n=decode(shown[4]). If BLANK_LZ=1 and shown[4]=0, an_n=11 instead, but the state still lasts CLK_DIV cycles (constant brightness). Then GAP1.
  - GAP1: like GAP0; GAP_CYC cycles, then DIG0.
  - blank=1 in any state: next edge -> OFF and counter cleared. blank has priority over counter expiry.
- Counter:
  - Counts 0..limit-1 within a state and is cleared on every state change.
  - Width = clog2(max(CLK_DIV, GAP_CYC)).
  - Wraps only via the state change; no overflow.
- decode, seg_n[6:0]=gfedcba, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - codes 10-15 -> 'E' 0000110
- Tens digit is 1 bit; shown[4]=1 always displays '1'.
- Period of one full frame = 2*(CLK_DIV+GAP_CYC) cycles.
- Reset asserted mid-frame: outputs go to reset values immediately (async), without waiting for a clock. After release, the first edge with blank=0 -> DIG0.
- Both anodes are never low in the same cycle. This is a required assertion.

Test Plan:
- Reset release, blank=0, no load -> next edge an_n=10, seg_n=1000000. After 4 cycles, an_n=11 for 1 cycle; then DIG1 with an_n=11 (LZ blank, tens=0) for 4 cycles; frame period 10.
- load with bcd_in=5'b1_0011 (13) during DIG0 -> load_ack 1 cycle later. Current frame still shows 0. Next DIG0: seg_n=0110000 (3). DIG1: an_n=01, seg_n=1111001 (1).
- load bcd_in=5'b0_1100 -> err=1 the cycle after hold updates. Next DIG0: seg_n=0000110 ('E').
- BLANK_LZ=0, hold=5'b0_0111 -> DIG1 shows an_n=01, seg_n=1000000; DIG0 shows 1111000.
- blank=1 asserted in mid DIG1 -> next edge an_n=11, seg_n=7F. Deassert -> next edge DIG0 with a fresh snapshot and counter at 0.
- rst_n pulled low asynchronously between edges while in DIG0 with hold=13 -> an_n=11, seg_n=7F immediately; hold=0, err=0. Scoreboard checks an_n!=00 throughout.
